// File: rtl/ls_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// funct3 access-size codes and the access legality check.
package ls_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } ls_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the size code exists for this direction and the address is
    // naturally aligned for it. Unsigned sizes only make sense for loads.
    function automatic logic access_legal(input logic [2:0] f3,
                                          input logic [1:0] addr_lo,
                                          input logic       is_store);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit.
//
// Handshake: the master raises mem_req together with mem_we, mem_addr,
// mem_be and mem_wdata and holds all of them stable until it samples
// mem_ack high on a rising edge; that edge completes the transfer (write
// accepted, or mem_rdata valid for a read). mem_ack while mem_req is low
// carries no meaning and is ignored.
interface load_store_unit_if;
    import ls_pkg::*;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/ls_align.sv
// Combinational data alignment: byte enables and lane replication for
// stores, lane selection and sign/zero extension for loads.
module ls_align
    import ls_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_value
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte and halfword lanes out of the read word.
    always_comb begin
        sel_byte = load_word[7:0];
        case (addr_lo)
            2'd0:    sel_byte = load_word[7:0];
            2'd1:    sel_byte = load_word[15:8];
            2'd2:    sel_byte = load_word[23:16];
            default: sel_byte = load_word[31:24];
        endcase
        sel_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    // Size-dependent enables, store replication and load extension.
    always_comb begin
        byte_en    = 4'b0000;
        store_word = store_data;
        load_value = 32'd0;
        case (funct3)
            F3_B: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
                load_value = {{24{sel_byte[7]}}, sel_byte};
            end
            F3_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
                load_value = {24'd0, sel_byte};
            end
            F3_H: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_value = {{16{sel_half[15]}}, sel_half};
            end
            F3_HU: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_value = {16'd0, sel_half};
            end
            F3_W: begin
                byte_en    = 4'b1111;
                store_word = store_data;
                load_value = load_word;
            end
            default: begin
                byte_en    = 4'b0000;
                store_word = store_data;
                load_value = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one access request from the core, checks it,
// runs a single held request on the memory bus (with a timeout) and
// reports completion with a one-cycle done pulse. All outputs registered.
module load_store_unit
    import ls_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output ls_state_t         state_dbg,
    load_store_unit_if.master mem
);

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    ls_state_t     state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    alo_q, alo_d;

    logic [2:0]    align_f3;
    logic [1:0]    align_alo;
    logic [3:0]    align_be;
    logic [31:0]   align_wdata;
    logic [31:0]   align_rdata;
    logic          rd_only;
    logic          wr_only;

    // In IDLE the aligner encodes the incoming store; afterwards it decodes
    // the returning word using the latched size and byte offset.
    assign align_f3  = (state_q == ST_IDLE) ? funct3          : f3_q;
    assign align_alo = (state_q == ST_IDLE) ? address[1:0]    : alo_q;
    assign rd_only   = mem_read & ~mem_write;
    assign wr_only   = mem_write & ~mem_read;

    ls_align u_align (
        .funct3     (align_f3),
        .addr_lo    (align_alo),
        .store_data (write_data),
        .load_word  (mem.mem_rdata),
        .byte_en    (align_be),
        .store_word (align_wdata),
        .load_value (align_rdata)
    );

    // Register every piece of state; reset abandons any access at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'b0000;
            rdata_q <= 32'd0;
            timer_q <= '0;
            f3_q    <= 3'b000;
            alo_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            timer_q <= timer_d;
            f3_q    <= f3_d;
            alo_q   <= alo_d;
        end
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fault_d = fault_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        timer_d = timer_q;
        f3_d    = f3_q;
        alo_d   = alo_q;

        case (state_q)
            ST_IDLE: begin
                if (start && (mem_read || mem_write)) begin
                    if ((rd_only && access_legal(funct3, address[1:0], 1'b0)) ||
                        (wr_only && access_legal(funct3, address[1:0], 1'b1))) begin
                        state_d = ST_REQ;
                        busy_d  = 1'b1;
                        fault_d = 1'b0;
                        req_d   = 1'b1;
                        we_d    = wr_only;
                        addr_d  = {address[31:2], 2'b00};
                        wdata_d = align_wdata;
                        be_d    = align_be;
                        timer_d = '0;
                        f3_d    = funct3;
                        alo_d   = address[1:0];
                    end else begin
                        // Rejected before any bus activity: report straight away.
                        state_d = ST_DONE;
                        busy_d  = 1'b1;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_ack) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b0;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = align_rdata;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                    rdata_d = 32'd0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                fault_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                fault_d = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    assign read_data     = rdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign fault         = fault_q;
    assign state_dbg     = state_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: clock/reset, driver tasks, checks
// against hand-computed values, final report.
module tb_load_store_unit;
    import ls_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic        fault;
    ls_state_t   state_dbg;

    int total;
    int bad;

    load_store_unit_if mem_if ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .state_dbg  (state_dbg),
        .mem        (mem_if.master)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one rising edge.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        start      = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        address    = addr;
        write_data = wd;
        tick();
        start     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Acknowledge for exactly one rising edge with the given read word.
    task automatic ack(input logic [31:0] rdata);
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = rdata;
        tick();
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'd0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; address = 32'd0; write_data = 32'd0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'd0;
        tick(); tick();

        // Reset state
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_req",   32'(mem_if.mem_req), 32'd0);
        chk("rst_be",    32'(mem_if.mem_be), 32'd0);
        chk("rst_addr",  mem_if.mem_addr, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        tick();

        // LW 0x10, ack in first REQ cycle; a second start while busy is ignored
        issue(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'd0);
        chk("lw_req",  32'(mem_if.mem_req), 32'd1);
        chk("lw_addr", mem_if.mem_addr, 32'h0000_0010);
        chk("lw_be",   32'(mem_if.mem_be), 32'hF);
        chk("lw_we",   32'(mem_if.mem_we), 32'd0);
        chk("lw_busy", 32'(busy), 32'd1);
        chk("lw_done_early", 32'(done), 32'd0);
        start = 1'b1; mem_write = 1'b1; funct3 = F3_W; address = 32'h0000_0080;
        ack(32'hDEAD_BEEF);
        start = 1'b0; mem_write = 1'b0;
        chk("lw_done",  32'(done), 32'd1);
        chk("lw_fault", 32'(fault), 32'd0);
        chk("lw_rdata", read_data, 32'hDEAD_BEEF);
        chk("lw_req_drop", 32'(mem_if.mem_req), 32'd0);
        chk("lw_busy_stall", 32'(mem_if.mem_addr), 32'h0000_0010);
        tick();
        chk("lw_done_once", 32'(done), 32'd0);
        chk("lw_idle_busy", 32'(busy), 32'd0);

        // LB 0x13 sign-extends lane 3
        issue(1'b1, 1'b0, F3_B, 32'h0000_0013, 32'd0);
        chk("lb_be",   32'(mem_if.mem_be), 32'h8);
        chk("lb_addr", mem_if.mem_addr, 32'h0000_0010);
        ack(32'h8012_3456);
        chk("lb_rdata", read_data, 32'hFFFF_FF80);
        tick();

        // LBU 0x13 zero-extends
        issue(1'b1, 1'b0, F3_BU, 32'h0000_0013, 32'd0);
        ack(32'h8012_3456);
        chk("lbu_rdata", read_data, 32'h0000_0080);
        tick();

        // SH 0x22 replicates the halfword into both lanes
        issue(1'b0, 1'b1, F3_H, 32'h0000_0022, 32'h1234_ABCD);
        chk("sh_we",    32'(mem_if.mem_we), 32'd1);
        chk("sh_be",    32'(mem_if.mem_be), 32'hC);
        chk("sh_wdata", mem_if.mem_wdata, 32'hABCD_ABCD);
        chk("sh_addr",  mem_if.mem_addr, 32'h0000_0020);
        ack(32'h5555_5555);
        chk("sh_done",  32'(done), 32'd1);
        chk("sh_rdata_hold", read_data, 32'h0000_0080);
        tick();

        // SB 0x11 replicates the byte into all lanes
        issue(1'b0, 1'b1, F3_B, 32'h0000_0011, 32'h0000_00A5);
        chk("sb_be",    32'(mem_if.mem_be), 32'h2);
        chk("sb_wdata", mem_if.mem_wdata, 32'hA5A5_A5A5);
        ack(32'd0);
        tick();

        // LH / LHU 0x22 take the upper halfword
        issue(1'b1, 1'b0, F3_H, 32'h0000_0022, 32'd0);
        chk("lh_be", 32'(mem_if.mem_be), 32'hC);
        ack(32'hBEEF_1234);
        chk("lh_rdata", read_data, 32'hFFFF_BEEF);
        tick();
        issue(1'b1, 1'b0, F3_HU, 32'h0000_0020, 32'd0);
        chk("lhu_be", 32'(mem_if.mem_be), 32'h3);
        ack(32'hBEEF_8234);
        chk("lhu_rdata", read_data, 32'h0000_8234);
        tick();

        // mem_ack while idle is ignored
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'd0;
        chk("idle_ack_done",  32'(done), 32'd0);
        chk("idle_ack_rdata", read_data, 32'h0000_8234);

        // LW 0x21 misaligned: fault without a bus request
        issue(1'b1, 1'b0, F3_W, 32'h0000_0021, 32'd0);
        chk("mis_req",   32'(mem_if.mem_req), 32'd0);
        chk("mis_done",  32'(done), 32'd1);
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_busy",  32'(busy), 32'd1);
        chk("mis_rdata", read_data, 32'h0000_8234);
        tick();
        chk("mis_clear", 32'(fault), 32'd0);

        // Both directions: fault
        issue(1'b1, 1'b1, F3_W, 32'h0000_0040, 32'd0);
        chk("both_fault", 32'(fault), 32'd1);
        chk("both_req",   32'(mem_if.mem_req), 32'd0);
        tick();

        // Unsigned size on a store: fault
        issue(1'b0, 1'b1, F3_BU, 32'h0000_0040, 32'd0);
        chk("sbu_fault", 32'(fault), 32'd1);
        tick();

        // Neither direction: ignored
        issue(1'b0, 1'b0, F3_W, 32'h0000_0040, 32'd0);
        chk("none_busy", 32'(busy), 32'd0);
        chk("none_done", 32'(done), 32'd0);

        // Timeout after 4 REQ cycles without ack
        issue(1'b1, 1'b0, F3_W, 32'h0000_0044, 32'd0);
        chk("to_req1", 32'(mem_if.mem_req), 32'd1);
        tick();
        chk("to_req2", 32'(mem_if.mem_req), 32'd1);
        tick();
        chk("to_req3", 32'(mem_if.mem_req), 32'd1);
        tick();
        chk("to_req4", 32'(mem_if.mem_req), 32'd1);
        chk("to_done_early", 32'(done), 32'd0);
        tick();
        chk("to_req_drop", 32'(mem_if.mem_req), 32'd0);
        chk("to_done",  32'(done), 32'd1);
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_rdata", read_data, 32'd0);
        tick();

        // Reset in the middle of REQ abandons the access
        issue(1'b1, 1'b0, F3_W, 32'h0000_0050, 32'd0);
        chk("mr_req", 32'(mem_if.mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_req_drop", 32'(mem_if.mem_req), 32'd0);
        chk("mr_busy",     32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_no_done", 32'(done), 32'd0);
        chk("mr_state",   32'(state_dbg), 32'(ST_IDLE));

        // Normal LW after the reset
        issue(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'd0);
        chk("post_req", 32'(mem_if.mem_req), 32'd1);
        ack(32'h1122_3344);
        chk("post_done",  32'(done), 32'd1);
        chk("post_rdata", read_data, 32'h1122_3344);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
